// File: rtl/mem_bist_pkg.sv
// rtl/mem_bist_pkg.sv - shared state encoding and expected-data helper for mem_bist_ram
// Contents:
//   MAX_W     widest data word exp_data can produce; callers cast down to their width
//   state_t   BIST sequencer states
//   exp_data  data a fill phase writes and the matching check phase expects
package mem_bist_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        FILL0,
        CHK0,
        FILLP,
        CHKP,
        FILLN,
        CHKN,
        DONE
    } state_t;

    // Zero phases use all-zero data. Pattern phases put PATTERN on even addresses
    // and its complement on odd ones. Inverted phases swap the two.
    function automatic logic [MAX_W-1:0] exp_data(
        input state_t           st,
        input logic [MAX_W-1:0] addr,
        input logic [MAX_W-1:0] pat
    );
        logic             odd;
        logic [MAX_W-1:0] r;
        odd = (addr & MAX_W'(1)) != '0;
        case (st)
            FILLP, CHKP: r = odd ? ~pat : pat;
            FILLN, CHKN: r = odd ? pat : ~pat;
            default:     r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bist_sp_ram.sv
// rtl/bist_sp_ram.sv - storage array with separate functional and self-test read registers
// Ports:
//   clk, reset            clock, asynchronous active-high reset (read registers only)
//   we, re, addr, wdata   single access port, shared by functional path and BIST
//   bist                  1: a read on this cycle loads bdata, 0: it loads rdata
//   flt_en, flt_addr      fault hook: writes to flt_addr store bit 0 as 1
//   rdata                 registered functional read data, held between reads
//   bdata                 registered BIST read data
module bist_sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              bist,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flt_en,
    input  logic [ADDR_W-1:0] flt_addr,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] bdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wval;

    always_comb begin
        wval = wdata;
        if (flt_en && (addr == flt_addr)) begin
            wval[0] = 1'b1;
        end
    end

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wval;
        end
    end

    // Reads sample the array before the same-edge write lands (read-before-write).
    // Keeping the BIST read register separate lets rdata hold across a self-test.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
            bdata <= '0;
        end else if (re) begin
            if (bist) begin
                bdata <= mem[addr];
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_bist_ram.sv
// rtl/mem_bist_ram.sv - single-port scratch RAM with a hardware fill/check self-test sequencer
// Optional: BIST_INV_PASS_EN appends an inverted-pattern fill/check pass (FILLN, CHKN).
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   we, re, addr, wdata     functional access, ignored while busy
//   rdata                   registered read data, valid the cycle after re
//   start                   launches a self-test when idle
//   busy                    self-test owns the array
//   done                    one-cycle pulse in the final sequencer cycle
//   pass                    last self-test saw no mismatch
//   err_cnt                 saturating mismatch count of the last self-test
//   fail_addr, fail_data    address and read value of the first mismatch
//   flt_en, flt_addr        fault hook forwarded to the array
module mem_bist_ram
    import mem_bist_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 5,
    parameter int                ERR_W   = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hAA)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    input  logic              flt_en,
    input  logic [ADDR_W-1:0] flt_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra counter bit gives check phases their trailing drain cycle.
    localparam logic [ADDR_W:0] LAST_FILL = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] LAST_CHK  = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   cnt;
    logic              is_fill;
    logic              is_chk;
    logic              phase_end;

    logic [ADDR_W-1:0] b_addr;
    logic              b_we;
    logic              b_re;
    logic [DATA_W-1:0] b_exp;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] bdata;

    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_exp;
    logic              mismatch;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        is_fill   = (state == FILL0) || (state == FILLP) || (state == FILLN);
        is_chk    = (state == CHK0) || (state == CHKP) || (state == CHKN);
        phase_end = is_fill ? (cnt == LAST_FILL) : (cnt == LAST_CHK);
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = FILL0;
            FILL0: if (phase_end) state_nxt = CHK0;
            CHK0:  if (phase_end) state_nxt = FILLP;
            FILLP: if (phase_end) state_nxt = CHKP;
`ifdef BIST_INV_PASS_EN
            CHKP:  if (phase_end) state_nxt = FILLN;
            FILLN: if (phase_end) state_nxt = CHKN;
            CHKN:  if (phase_end) state_nxt = DONE;
`else
            CHKP:  if (phase_end) state_nxt = DONE;
`endif
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Restarting at zero on every state change keeps each phase aligned to address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state != IDLE) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        b_addr = cnt[ADDR_W-1:0];
        b_we   = is_fill;
        b_re   = is_chk && !cnt[ADDR_W];
        b_exp  = DATA_W'(exp_data(state, MAX_W'(b_addr), MAX_W'(PATTERN)));
    end

    // The sequencer takes the port whenever it is busy; in IDLE, including the
    // start cycle, the functional access goes through untouched.
    always_comb begin
        ram_we    = busy ? b_we : we;
        ram_re    = busy ? b_re : re;
        ram_addr  = busy ? b_addr : addr;
        ram_wdata = busy ? b_exp : wdata;
    end

    bist_sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .we       (ram_we),
        .re       (ram_re),
        .bist     (busy),
        .addr     (ram_addr),
        .wdata    (ram_wdata),
        .flt_en   (flt_en),
        .flt_addr (flt_addr),
        .rdata    (rdata),
        .bdata    (bdata)
    );

    // Expected value and address travel one stage alongside the registered read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_vld  <= 1'b0;
            cmp_addr <= '0;
            cmp_exp  <= '0;
        end else begin
            cmp_vld  <= b_re;
            cmp_addr <= b_addr;
            cmp_exp  <= b_exp;
        end
    end

    assign mismatch = cmp_vld && (bdata != cmp_exp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
        end else begin
            if (mismatch) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (err_cnt == '0) begin
                    fail_addr <= cmp_addr;
                    fail_data <= bdata;
                end
            end
            // The final compare has already landed in err_cnt by the DONE cycle.
            if (state == DONE) begin
                pass <= (err_cnt == '0);
            end
        end
    end

endmodule
